// File: rtl/pic_rom_arbiter.sv
// Picture ROM arbiter: the display reader always owns the ROM port; an
// auxiliary reader is served only in cycles where the display is idle.
module pic_rom_arbiter #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ROM_DEPTH    = 10000,
    parameter int unsigned STARVE_LIMIT = 1024
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    input  logic              disp_rd_en,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_ack,
    output logic              aux_err,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_rvalid,
    output logic              aux_starved,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rden,
    input  logic [DATA_W-1:0] rom_q
);

    localparam int unsigned CNT_W = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_PEND = 2'd1,
        A_WAIT = 2'd2
    } aux_state_t;

    aux_state_t        state;
    aux_state_t        state_d;
    logic [ADDR_W-1:0] aux_addr_q;
    logic [ADDR_W-1:0] aux_addr_d;
    logic [CNT_W-1:0]  pend_cnt;
    logic [CNT_W-1:0]  pend_cnt_d;
    logic              aux_ack_d;
    logic              aux_err_d;
    logic              aux_rvalid_d;
    logic [DATA_W-1:0] aux_rdata_d;
    logic              aux_issue;
    logic              aux_in_range;

    assign aux_in_range = 32'(aux_addr) < ROM_DEPTH;

    // ROM port mux: display has absolute priority, aux only fills idle slots
    assign rom_rden = disp_rd_en | aux_issue;
    assign rom_addr = disp_rd_en ? disp_addr : (aux_issue ? aux_addr_q : '0);

    // Display data is gated so the bus reads zero outside valid cycles
    assign disp_data = disp_valid ? rom_q : '0;

    // Starvation is status only; it never preempts the display
    assign aux_starved = (state == A_PEND) && (32'(pend_cnt) >= STARVE_LIMIT);

    // Aux next-state, handshake pulses, capture and wait counter
    always_comb begin
        state_d      = state;
        aux_addr_d   = aux_addr_q;
        pend_cnt_d   = pend_cnt;
        aux_ack_d    = 1'b0;
        aux_err_d    = 1'b0;
        aux_rvalid_d = 1'b0;
        aux_rdata_d  = aux_rdata;
        aux_issue    = 1'b0;
        unique case (state)
            A_IDLE: begin
                if (aux_req) begin
                    aux_ack_d = 1'b1;
                    if (aux_in_range) begin
                        aux_addr_d = aux_addr;
                        pend_cnt_d = '0;
                        state_d    = A_PEND;
                    end else begin
                        aux_err_d = 1'b1;
                    end
                end
            end
            A_PEND: begin
                aux_issue = !disp_rd_en;
                if (pend_cnt != CNT_MAX) begin
                    pend_cnt_d = pend_cnt + CNT_W'(1);
                end
                if (aux_issue) begin
                    state_d = A_WAIT;
                end
            end
            A_WAIT: begin
                // rom_q here belongs to the aux issue of the previous cycle
                aux_rdata_d  = rom_q;
                aux_rvalid_d = 1'b1;
                state_d      = A_IDLE;
            end
            default: begin
                state_d = A_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= A_IDLE;
            aux_addr_q <= '0;
            pend_cnt   <= '0;
            aux_ack    <= 1'b0;
            aux_err    <= 1'b0;
            aux_rvalid <= 1'b0;
            aux_rdata  <= '0;
            disp_valid <= 1'b0;
        end else begin
            state      <= state_d;
            aux_addr_q <= aux_addr_d;
            pend_cnt   <= pend_cnt_d;
            aux_ack    <= aux_ack_d;
            aux_err    <= aux_err_d;
            aux_rvalid <= aux_rvalid_d;
            aux_rdata  <= aux_rdata_d;
            disp_valid <= disp_rd_en;
        end
    end

endmodule

// File: tb/tb_pic_rom_arbiter.sv
// Directed bench for pic_rom_arbiter with a registered-output ROM model.
module tb_pic_rom_arbiter;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 16;

    logic              vga_clk = 1'b0;
    logic              sys_rst_n;
    logic              disp_rd_en;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              aux_req;
    logic [ADDR_W-1:0] aux_addr;
    logic              aux_ack;
    logic              aux_err;
    logic [DATA_W-1:0] aux_rdata;
    logic              aux_rvalid;
    logic              aux_starved;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rden;
    logic [DATA_W-1:0] rom_q;

    int vectors     = 0;
    int miscompares = 0;

    pic_rom_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .ROM_DEPTH   (10000),
        .STARVE_LIMIT(16)
    ) dut (
        .vga_clk    (vga_clk),
        .sys_rst_n  (sys_rst_n),
        .disp_rd_en (disp_rd_en),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .aux_req    (aux_req),
        .aux_addr   (aux_addr),
        .aux_ack    (aux_ack),
        .aux_err    (aux_err),
        .aux_rdata  (aux_rdata),
        .aux_rvalid (aux_rvalid),
        .aux_starved(aux_starved),
        .rom_addr   (rom_addr),
        .rom_rden   (rom_rden),
        .rom_q      (rom_q)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [15:0] rom_word(input logic [13:0] a);
        logic [15:0] w;
        w = {2'b00, a};
        return (w * 16'd37) ^ 16'h5A5A;
    endfunction

    // ROM model: one cycle read latency, output held between reads
    always_ff @(posedge vga_clk) begin
        if (rom_rden) rom_q <= rom_word(rom_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge vga_clk);
    endtask

    // Single in-range aux read with the display idle
    task automatic aux_read(input logic [13:0] a, input string tag);
        next_cyc(); aux_req = 1'b1; aux_addr = a; at_sample();
        check({tag, "_ack_T"}, 32'(aux_ack), 0);
        check({tag, "_rden_T"}, 32'(rom_rden), 0);
        next_cyc(); aux_req = 1'b0; at_sample();
        check({tag, "_ack_T1"}, 32'(aux_ack), 1);
        check({tag, "_err_T1"}, 32'(aux_err), 0);
        check({tag, "_rden_T1"}, 32'(rom_rden), 1);
        check({tag, "_addr_T1"}, 32'(rom_addr), 32'(a));
        next_cyc(); at_sample();
        check({tag, "_ack_T2"}, 32'(aux_ack), 0);
        check({tag, "_rden_T2"}, 32'(rom_rden), 0);
        check({tag, "_rvalid_T2"}, 32'(aux_rvalid), 0);
        next_cyc(); at_sample();
        check({tag, "_rvalid_T3"}, 32'(aux_rvalid), 1);
        check({tag, "_rdata_T3"}, 32'(aux_rdata), 32'(rom_word(a)));
        next_cyc(); at_sample();
        check({tag, "_rvalid_T4"}, 32'(aux_rvalid), 0);
        check({tag, "_rdata_hold"}, 32'(aux_rdata), 32'(rom_word(a)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_disp_data"}, 32'(disp_data), 0);
        check({tag, "_disp_valid"}, 32'(disp_valid), 0);
        check({tag, "_aux_ack"}, 32'(aux_ack), 0);
        check({tag, "_aux_err"}, 32'(aux_err), 0);
        check({tag, "_aux_rdata"}, 32'(aux_rdata), 0);
        check({tag, "_aux_rvalid"}, 32'(aux_rvalid), 0);
        check({tag, "_aux_starved"}, 32'(aux_starved), 0);
        check({tag, "_rom_rden"}, 32'(rom_rden), 0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 0);
    endtask

    initial begin
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        sys_rst_n  = 1'b0;
        disp_rd_en = 1'b0;
        disp_addr  = '0;
        aux_req    = 1'b0;
        aux_addr   = '0;

        // Power-on reset
        at_sample();
        check_all_zero("por");
        next_cyc(); sys_rst_n = 1'b1;

        // Display-only stream of 100 addresses
        for (int i = 0; i < 102; i++) begin
            next_cyc();
            disp_rd_en = (i < 100);
            disp_addr  = (i < 100) ? 14'(i) : '0;
            at_sample();
            exp_data = (i >= 1 && i <= 100) ? 32'(rom_word(14'(i - 1))) : 0;
            if (i < 100) check($sformatf("stream_addr[%0d]", i), 32'(rom_addr), i);
            check($sformatf("stream_rden[%0d]", i), 32'(rom_rden), 32'(i < 100));
            check($sformatf("stream_valid[%0d]", i), 32'(disp_valid), 32'(i >= 1 && i <= 100));
            check($sformatf("stream_data[%0d]", i), 32'(disp_data), exp_data);
        end

        // Aux read in blanking
        aux_read(14'd5, "blank");

        // Aux request during an active line; display keeps every slot
        for (int i = 0; i < 103; i++) begin
            next_cyc();
            disp_rd_en = (i < 100);
            disp_addr  = 14'(200 + i);
            aux_req    = (i == 10);
            aux_addr   = 14'd77;
            at_sample();
            if (i < 100)       exp_addr = 32'(200 + i);
            else if (i == 100) exp_addr = 77;
            else               exp_addr = 0;
            exp_data = (i >= 1 && i <= 100) ? 32'(rom_word(14'(200 + i - 1))) : 0;
            check($sformatf("line_rden[%0d]", i), 32'(rom_rden), 32'(i <= 100));
            check($sformatf("line_addr[%0d]", i), 32'(rom_addr), exp_addr);
            check($sformatf("line_valid[%0d]", i), 32'(disp_valid), 32'(i >= 1 && i <= 100));
            check($sformatf("line_data[%0d]", i), 32'(disp_data), exp_data);
            check($sformatf("line_ack[%0d]", i), 32'(aux_ack), 32'(i == 11));
            check($sformatf("line_starved[%0d]", i), 32'(aux_starved), 32'(i >= 27 && i <= 100));
            check($sformatf("line_rvalid[%0d]", i), 32'(aux_rvalid), 32'(i == 102));
        end
        check("line_rdata", 32'(aux_rdata), 32'(rom_word(14'd77)));

        // Starvation: display held 40 cycles with aux pending
        for (int i = 0; i < 43; i++) begin
            next_cyc();
            disp_rd_en = (i < 40);
            disp_addr  = 14'(i);
            aux_req    = (i == 0);
            aux_addr   = 14'd9;
            at_sample();
            check($sformatf("starve_flag[%0d]", i), 32'(aux_starved), 32'(i >= 17 && i <= 40));
            check($sformatf("starve_rvalid[%0d]", i), 32'(aux_rvalid), 32'(i == 42));
            if (i == 40) check("starve_issue_addr", 32'(rom_addr), 9);
        end
        check("starve_rdata", 32'(aux_rdata), 32'(rom_word(14'd9)));

        // Out-of-range request is acked with error and never touches the ROM
        next_cyc(); aux_req = 1'b1; aux_addr = 14'd10000; at_sample();
        check("oor_rden_T", 32'(rom_rden), 0);
        next_cyc(); aux_req = 1'b0; at_sample();
        check("oor_ack", 32'(aux_ack), 1);
        check("oor_err", 32'(aux_err), 1);
        check("oor_rden_T1", 32'(rom_rden), 0);
        next_cyc(); at_sample();
        check("oor_ack_clr", 32'(aux_ack), 0);
        check("oor_err_clr", 32'(aux_err), 0);
        check("oor_rden_T2", 32'(rom_rden), 0);
        next_cyc(); at_sample();
        check("oor_rvalid", 32'(aux_rvalid), 0);
        check("oor_rdata_hold", 32'(aux_rdata), 32'(rom_word(14'd9)));
        aux_read(14'd9999, "last");

        // Reset while aux is pending behind an active display
        next_cyc(); disp_rd_en = 1'b1; disp_addr = 14'd50; aux_req = 1'b1; aux_addr = 14'd3;
        next_cyc(); aux_req = 1'b0; at_sample();
        check("midrst_ack", 32'(aux_ack), 1);
        next_cyc(); sys_rst_n = 1'b0; disp_rd_en = 1'b0; #1;
        check_all_zero("midrst");
        next_cyc(); sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            at_sample();
            check($sformatf("postrst_ack[%0d]", i), 32'(aux_ack), 0);
            check($sformatf("postrst_rvalid[%0d]", i), 32'(aux_rvalid), 0);
            check($sformatf("postrst_rden[%0d]", i), 32'(rom_rden), 0);
            next_cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pic_rom_arbiter.md
Name: pic_rom_arbiter

Overview:
- Shares the single-port on-chip picture ROM between two requesters.
  - The VGA display reader is hard real-time. It is always granted, with 1-cycle read latency.
  - An auxiliary reader (debug readback / checksum engine) is served only in cycles where the display is not reading, e.g. blanking or outside the picture window.
- Sits between the picture display logic and the pic_rom instance, in the vga_clk domain.

Parameters:
- ADDR_W, 14, ROM address width.
- DATA_W, 16, ROM word width (RGB565).
- ROM_DEPTH, 10000, number of valid ROM words; aux addresses >= ROM_DEPTH are rejected.
- STARVE_LIMIT, 1024, cycles an accepted aux request may wait before aux_starved asserts.

Ports:
- vga_clk  in  1  pixel clock
- sys_rst_n  in  1  reset
- disp_rd_en  in  1  display read request, level, per cycle
- disp_addr  in  ADDR_W  display read address
- disp_data  out  DATA_W  display read data
- disp_valid  out  1  disp_data valid
- aux_req  in  1  aux read request, level
- aux_addr  in  ADDR_W  aux read address, sampled on accept
- aux_ack  out  1  1-cycle pulse: request accepted (or rejected)
- aux_err  out  1  1-cycle pulse with aux_ack: address out of range
- aux_rdata  out  DATA_W  aux read data, held until next aux capture
- aux_rvalid  out  1  1-cycle pulse: aux_rdata updated
- aux_starved  out  1  aux request pending >= STARVE_LIMIT cycles
- rom_addr  out  ADDR_W  to ROM address
- rom_rden  out  1  to ROM read enable
- rom_q  in  DATA_W  ROM output, valid 1 cycle after rom_rden

Behaviour:
- Clock and reset: reset sys_rst_n, asynchronous, active-low; clock vga_clk.
- Reset values: all registers and registered outputs are 0; aux FSM is A_IDLE.
  - Resulting outputs: disp_data=0, disp_valid=0, aux_ack=0, aux_err=0, aux_rdata=0, aux_rvalid=0, aux_starved=0, rom_rden=0, rom_addr=0.
- Reset mid-operation: a pending aux request is discarded; no ack, rvalid or err is produced for it.
- Display path (combinational issue, no bubbles):
  - rom_rden = disp_rd_en | aux_issue.
  - rom_addr = disp_rd_en ? disp_addr : (aux_issue ? aux_addr_q : 0).
  - disp_valid is registered from disp_rd_en (1 cycle).
  - disp_data = disp_valid ? rom_q : 0.
  - Display latency is exactly 1 cycle in all cases; aux activity never delays or blocks it.
- Aux FSM, states A_IDLE, A_PEND, A_WAIT:
  - A_IDLE, aux_req=1, aux_addr < ROM_DEPTH:
    - latch aux_addr_q; aux_ack registered pulse (visible the next cycle); go to A_PEND.
  - A_IDLE, aux_req=1, aux_addr >= ROM_DEPTH:
    - aux_ack and aux_err pulse together; no ROM access; stay in A_IDLE.
  - A_PEND:
    - aux_issue = !disp_rd_en (combinational).
    - If aux_issue, go to A_WAIT; otherwise stay (display wins every conflict).
  - A_WAIT:
    - capture rom_q into aux_rdata; aux_rvalid=1 the next cycle; go to A_IDLE.
  - aux_req is ignored outside A_IDLE.
  - A level still high in A_IDLE after completion is a new request; the requester drops aux_req after seeing aux_ack.
  - Timing with the display idle: req seen in cycle T → ack at T+1, ROM issue at T+1, rvalid and data at T+3.
- Starvation:
  - An 11-bit counter clears on entry to A_PEND and increments each cycle in A_PEND, saturating at 2047.
  - aux_starved = (state==A_PEND) && (count >= STARVE_LIMIT).
  - It drops the cycle after the issue.
  - It is status only: no preemption of the display.
- Simultaneous events:
  - disp_rd_en rising in the same cycle an aux issue would occur → display wins, aux stays in A_PEND.
  - A_WAIT capture is unaffected by disp_rd_en in that cycle, since rom_q then belongs to the aux issue.
- Widths and range:
  - Address compare is unsigned, ADDR_W bits.
  - Address 9999 is valid; address 10000 is out of range.
  - No address wrap is performed here; the display side owns wrap-around.

Test Plan:
- Reset check: assert sys_rst_n=0 mid-run with aux in A_PEND → all outputs 0 immediately. After release, no aux_ack or aux_rvalid appears for the dropped request.
- Display stream: disp_rd_en=1 for 100 cycles, disp_addr 0..99 →
  - rom_addr equals disp_addr in the same cycle;
  - disp_valid is high for the 100 cycles starting 1 cycle later;
  - disp_data equals the ROM model word for each address, and 0 when disp_valid=0.
- Aux in blanking: disp_rd_en=0, aux_req=1, aux_addr=5 in cycle T →
  - aux_ack at T+1;
  - rom_rden=1 with rom_addr=5 at T+1;
  - aux_rvalid=1 at T+3 with aux_rdata=ROM[5];
  - aux_rdata is held afterwards.
- Aux during active line: disp_rd_en=1 for cycles 0..99, aux request accepted at cycle 10 →
  - no aux ROM access before cycle 100;
  - aux issued at cycle 100 with rom_addr=aux_addr_q;
  - display data and valid are bit-exact versus the display-only run.
- Starvation (STARVE_LIMIT=16): disp_rd_en held 40 cycles with an aux request pending →
  - aux_starved rises after 16 cycles in A_PEND;
  - it stays high until the issue cycle, then drops.
- Out of range: aux_addr=10000 → aux_ack and aux_err pulse together; rom_rden stays 0 (display idle); no aux_rvalid. Then aux_addr=9999 → normal read of ROM[9999].
